cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have I-side ports: i_pmem_read in 1, i_pmem_address in ADDR_W, i_pmem_rdata out LINE_W, i_pmem_resp out 1.
REQ-006 SHALL have D-side ports: d_pmem_read in 1, d_pmem_write in 1, d_pmem_address in ADDR_W, d_pmem_wdata in LINE_W, d_pmem_rdata out LINE_W, d_pmem_resp out 1.
REQ-007 SHALL have memory-side ports: mem_read out 1, mem_write out 1, mem_address out ADDR_W, mem_wdata out LINE_W, mem_rdata in LINE_W, mem_resp in 1.
REQ-008 SHALL have status port: last_grant_d out 1, 1 when most recent completed grant was D-side.

Function
REQ-009 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RELEASE.
REQ-010 IDLE: no mem_read/mem_write asserted; evaluates requests each cycle.
REQ-011 I request = i_pmem_read; D request = d_pmem_read | d_pmem_write.
REQ-012 IDLE, only I request -> SERVE_I next cycle; only D request -> SERVE_D next cycle.
REQ-013 IDLE, both request -> grant side opposite to last_grant_d (round-robin); last_grant_d=1 -> SERVE_I, else SERVE_D.
REQ-014 SERVE_I: mem_read=1, mem_address=i_pmem_address, mem_write=0, mem_wdata don't-care.
REQ-015 SERVE_D: mem_read=d_pmem_read, mem_write=d_pmem_write, mem_address=d_pmem_address, mem_wdata=d_pmem_wdata.
REQ-016 d_pmem_read and d_pmem_write both high is illegal; bench SHALL flag it as assertion failure.
REQ-017 On mem_resp in SERVE_x: assert x_pmem_resp=1 same cycle (combinational), x_pmem_rdata=mem_rdata; next state RELEASE; update last_grant_d.
REQ-018 x_pmem_resp SHALL be 1 for exactly one cycle per transaction; non-granted side resp SHALL be 0.
REQ-019 i_pmem_rdata and d_pmem_rdata SHALL both mirror mem_rdata at all times; only resp qualifies validity.
REQ-020 RELEASE: mem_read=mem_write=0 for one cycle (lets requester drop/change request), then IDLE.
REQ-021 Latency: request seen in IDLE at cycle t -> memory command at t+1; minimum request-to-resp = 1 + memory latency; back-to-back transactions separated by RELEASE + IDLE (2 idle cycles).
REQ-022 Granted requester SHALL hold request stable until its resp; arbiter holds state until mem_resp regardless of request deassertion.
REQ-023 mem_resp in IDLE or RELEASE SHALL be ignored (no resp forwarded, no state change).
REQ-024 Non-granted request asserted during a transaction SHALL wait; no starvation: each side is served within at most one other-side transaction after becoming pending.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE and last_grant_d=1 (I-side wins first tie).
REQ-026 During/after reset: mem_read=0, mem_write=0, i_pmem_resp=0, d_pmem_resp=0; address/wdata outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it without forwarding resp; pending memory completion arriving post-reset ignored per REQ-023.

Verification
REQ-028 I-only: i_pmem_read=1, addr 0x60 -> mem_read=1, mem_address=0x60 next cycle; mem_resp with rdata pattern A -> i_pmem_resp=1 one cycle, i_pmem_rdata=A.
REQ-029 Simultaneous after reset: I read 0x100, D write 0x200 -> I served first, then D (mem_write=1, mem_address=0x200, wdata passed); last_grant_d ends 1.
REQ-030 Continuous contention, 6 transactions -> grants alternate I,D,I,D,I,D; each resp pulse exactly one cycle.
REQ-031 Spurious mem_resp in IDLE -> no resp on either side, stays IDLE.
REQ-032 rst asserted while SERVE_D waiting -> next cycle IDLE, mem_write=0, d_pmem_resp never pulses; later mem_resp ignored.
REQ-033 D read 0x80, memory resp after 10 cycles -> mem_read held 10 cycles, d_pmem_resp at resp cycle, RELEASE then IDLE.

Source files
------------

// File: rtl/cache_arbiter.sv
// Arbitrates a shared line-wide memory port between an I-cache and a D-cache.
// Ties go to the side that was not granted last; each transaction ends with a RELEASE cycle.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  // data side
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  // status
  output logic              last_grant_d
);

  // state    | meaning
  // IDLE     | no command on memory; evaluate requests
  // SERVE_I  | I-side read on memory, waiting for mem_resp
  // SERVE_D  | D-side read or write on memory, waiting for mem_resp
  // RELEASE  | one quiet cycle so the requester can drop or change its request
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   grant_d_q, grant_d_d;
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d_d   = grant_d_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = grant_d_q ? SERVE_I : SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_pmem_address;
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          grant_d_d   = 1'b0;
          state_d     = RELEASE;
        end
      end
      SERVE_D: begin
        mem_read    = d_pmem_read;
        mem_write   = d_pmem_write;
        mem_address = d_pmem_address;
        mem_wdata   = d_pmem_wdata;
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          grant_d_d   = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reset silences the memory command and any response in the same cycle it is asserted.
    if (rst) begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
    end
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign last_grant_d = grant_d_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a latency-programmable memory model answers commands,
// expected transactions are queued at stimulus time and popped when a resp pulse appears.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk, rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read, d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          last_grant_d;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .last_grant_d(last_grant_d)
  );

  typedef struct {
    logic          side;
    logic [AW-1:0] addr;
    logic          write;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_lat  = 3;
  logic spur_go  = 1'b0;
  logic prev_resp = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = a ^ (32'h5A5A_0000 + 32'(k));
    return r;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic side, input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
    exp_t e;
    e.side  = side;
    e.addr  = a;
    e.write = w;
    e.wdata = wd;
    e.rdata = pat(a);
    sb.push_back(e);
  endtask

  task automatic wait_resp(input logic side);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = side ? d_pmem_resp : i_pmem_resp;
    end
    check(side ? "d_resp_timeout" : "i_resp_timeout", LW'(got), LW'(1));
  endtask

  // Memory model: answers a command mem_lat cycles after it first appears.
  initial begin
    logic [AW-1:0] a;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spur_go) begin
        mem_rdata = pat(32'hDEAD_0000);
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
      end else if (!rst && (mem_read || mem_write)) begin
        a = mem_address;
        repeat (mem_lat - 1) begin
          @(posedge clk);
          #1;
        end
        mem_rdata = pat(a);
        mem_resp  = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(d_pmem_read && d_pmem_write))
      else $error("FAIL illegal_d_rw: d_pmem_read and d_pmem_write both high");
  end

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("resp_in_reset", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
      prev_resp = 1'b0;
    end else begin
      check("rdata_mirror", LW'((i_pmem_rdata === mem_rdata) && (d_pmem_rdata === mem_rdata)), LW'(1));
      if (i_pmem_resp || d_pmem_resp) begin
        check("resp_one_cycle", LW'(prev_resp), LW'(0));
        check("dual_resp", LW'(i_pmem_resp && d_pmem_resp), LW'(0));
        if (sb.size() == 0) begin
          check("unexpected_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
        end else begin
          e = sb.pop_front();
          check("resp_side", LW'(d_pmem_resp), LW'(e.side));
          check("cmd_addr", LW'(mem_address), LW'(e.addr));
          check("cmd_write", LW'(mem_write), LW'(e.write));
          check("cmd_read", LW'(mem_read), LW'(!e.write));
          if (e.write) check("cmd_wdata", mem_wdata, e.wdata);
          check("resp_rdata", e.side ? d_pmem_rdata : i_pmem_rdata, e.rdata);
        end
      end
      prev_resp = i_pmem_resp || d_pmem_resp;
    end
  end

  initial begin
    int held;
    logic got;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", LW'(mem_read), LW'(0));
    check("rst_mem_write", LW'(mem_write), LW'(0));
    check("rst_mem_addr", LW'(mem_address), LW'(0));
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_last_grant", LW'(last_grant_d), LW'(1));
    @(posedge clk); #1 rst = 1'b0;

    // I-only read, command one cycle after the request
    @(posedge clk); #1;
    mem_lat = 3;
    i_pmem_read = 1'b1; i_pmem_address = 32'h60;
    push(1'b0, 32'h60, 1'b0, '0);
    @(negedge clk);
    check("idle_no_cmd", LW'(mem_read), LW'(0));
    @(negedge clk);
    check("i_cmd_read", LW'(mem_read), LW'(1));
    check("i_cmd_addr", LW'(mem_address), LW'(32'h60));
    wait_resp(1'b0);
    @(posedge clk); #1 i_pmem_read = 1'b0;
    repeat (3) @(negedge clk);
    check("grant_after_i", LW'(last_grant_d), LW'(0));

    // simultaneous after reset: I first, then the D write
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = pat(32'hBEEF);
    push(1'b0, 32'h100, 1'b0, '0);
    push(1'b1, 32'h200, 1'b1, pat(32'hBEEF));
    fork
      begin wait_resp(1'b0); @(posedge clk); #1 i_pmem_read = 1'b0; end
      begin wait_resp(1'b1); @(posedge clk); #1 d_pmem_write = 1'b0; end
    join
    @(negedge clk);
    check("grant_after_tie", LW'(last_grant_d), LW'(1));

    // continuous contention: I,D,I,D,I,D
    mem_lat = 2;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 32'h1000 + 32'(k * 64), 1'b0, '0);
      push(1'b1, 32'h2000 + 32'(k * 64), k[0], pat(32'h7700 + 32'(k)));
    end
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          i_pmem_read = 1'b1; i_pmem_address = 32'h1000 + 32'(k * 64);
          wait_resp(1'b0);
          @(posedge clk); #1;
        end
        i_pmem_read = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          d_pmem_read = !k[0]; d_pmem_write = k[0];
          d_pmem_address = 32'h2000 + 32'(k * 64); d_pmem_wdata = pat(32'h7700 + 32'(k));
          wait_resp(1'b1);
          @(posedge clk); #1;
        end
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      end
    join
    @(negedge clk);
    check("grant_after_contention", LW'(last_grant_d), LW'(1));
    check("contention_drained", LW'(sb.size()), LW'(0));

    // spurious mem_resp while idle
    repeat (2) @(negedge clk);
    spur_go = 1'b1;
    @(posedge clk); #2 spur_go = 1'b0;
    @(negedge clk);
    check("spur_no_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("spur_stay_idle", LW'({mem_read, mem_write}), LW'(0));
    end

    // reset while SERVE_D waits on a write; late completion ignored
    mem_lat = 6;
    @(posedge clk); #1;
    d_pmem_write = 1'b1; d_pmem_address = 32'h300; d_pmem_wdata = pat(32'h3300);
    @(negedge clk);
    @(negedge clk);
    check("abort_cmd_write", LW'(mem_write), LW'(1));
    @(posedge clk); #1;
    rst = 1'b1; d_pmem_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_idle_write", LW'(mem_write), LW'(0));
    check("abort_idle_read", LW'(mem_read), LW'(0));
    check("abort_grant", LW'(last_grant_d), LW'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_quiet", LW'({mem_read, mem_write, d_pmem_resp}), LW'(0));
    end

    // long-latency D read
    mem_lat = 10;
    @(posedge clk); #1;
    d_pmem_read = 1'b1; d_pmem_address = 32'h80;
    push(1'b1, 32'h80, 1'b0, '0);
    held = 0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (mem_read) held++;
      got = d_pmem_resp;
    end
    check("long_resp_seen", LW'(got), LW'(1));
    check("long_read_held", LW'(held), LW'(10));
    @(posedge clk); #1 d_pmem_read = 1'b0;
    @(negedge clk);
    check("long_release", LW'({mem_read, mem_write}), LW'(0));
    @(negedge clk);
    check("long_idle", LW'({mem_read, mem_write}), LW'(0));
    check("long_grant", LW'(last_grant_d), LW'(1));

    repeat (3) @(negedge clk);
    check("sb_empty", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
